// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe turn sequencer.
package ttt_pkg;
  localparam int GRID_BITS_DEF = 2;

  typedef enum logic [1:0] {S_WAIT, S_ISSUE, S_RESULT, S_DONE} state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam logic P1 = 1'b0;
  localparam logic P2 = 1'b1;

  function automatic logic [1:0] win_code(input logic player);
    return (player == P2) ? WIN_P2 : WIN_P1;
  endfunction
endpackage

// File: rtl/ttt_req_edge.sv
// Rising-edge detector for one player's request level, with coordinate capture.
module ttt_req_edge #(
  parameter int GRID_BITS = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 req,
  input  logic [GRID_BITS-1:0] req_row,
  input  logic [GRID_BITS-1:0] req_col,
  output logic                 rise,
  output logic [GRID_BITS-1:0] row,
  output logic [GRID_BITS-1:0] col
);
  logic                 req_q;
  logic [GRID_BITS-1:0] row_q;
  logic [GRID_BITS-1:0] col_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      req_q <= 1'b0;
      row_q <= '0;
      col_q <= '0;
    end else begin
      req_q <= req;
      if (rise) begin
        row_q <= req_row;
        col_q <= req_col;
      end
    end
  end

  assign rise = req & ~req_q;
  // Live coordinates on the edge cycle so the move can issue the very next cycle.
  assign row  = rise ? req_row : row_q;
  assign col  = rise ? req_col : col_q;
endmodule

// File: rtl/ttt_turn_sequencer.sv
// Turn controller: alternates players, serialises moves to the board core, tracks result.
// state    | meaning
// S_WAIT   | waiting for the current player's request; timeout runs
// S_ISSUE  | move offered on mv_*, waiting for mv_ready
// S_RESULT | waiting for the board verdict
// S_DONE   | game finished, waiting for new_game
module ttt_turn_sequencer
  import ttt_pkg::*;
#(
  parameter int   GRID_BITS      = GRID_BITS_DEF,
  parameter int   TIMEOUT_CYCLES = 255,
  parameter logic FIRST_PLAYER   = 1'b0
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   new_game,
  input  logic                   player1,
  input  logic [GRID_BITS-1:0]   a,
  input  logic [GRID_BITS-1:0]   b,
  input  logic                   player2,
  input  logic [GRID_BITS-1:0]   c,
  input  logic [GRID_BITS-1:0]   d,
  output logic                   mv_valid,
  input  logic                   mv_ready,
  output logic                   mv_player,
  output logic [GRID_BITS-1:0]   mv_row,
  output logic [GRID_BITS-1:0]   mv_col,
  input  logic                   res_valid,
  input  logic                   res_illegal,
  input  logic                   res_win,
  input  logic                   res_full,
  output logic                   turn,
  output logic                   ack1,
  output logic                   ack2,
  output logic                   rej1,
  output logic                   rej2,
  output logic                   timeout_evt,
  output logic [2*GRID_BITS:0]   move_count,
  output logic                   game_over,
  output logic [1:0]             winner
);
  localparam int CW       = 2*GRID_BITS + 1;
  localparam int CELLS_I  = 1 << (2*GRID_BITS);
  localparam logic [CW-1:0] CELLS = CW'(CELLS_I);
  localparam int TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES);

  state_t                state;
  logic   [TW-1:0]       tmo_q;
  logic                  rise1, rise2, cur_rise, tmo_hit;
  logic [GRID_BITS-1:0]  row1, col1, row2, col2;
  logic [CW-1:0]         count_inc;

  ttt_req_edge #(.GRID_BITS(GRID_BITS)) u_edge1 (
    .clk(clk), .resetn(resetn), .req(player1), .req_row(a), .req_col(b),
    .rise(rise1), .row(row1), .col(col1)
  );

  ttt_req_edge #(.GRID_BITS(GRID_BITS)) u_edge2 (
    .clk(clk), .resetn(resetn), .req(player2), .req_row(c), .req_col(d),
    .rise(rise2), .row(row2), .col(col2)
  );

  assign cur_rise  = (turn == P2) ? rise2 : rise1;
  assign tmo_hit   = (TIMEOUT_CYCLES != 0) && (tmo_q == TW'(1));
  assign count_inc = (move_count == CELLS) ? move_count : move_count + CW'(1);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= S_WAIT;
      turn        <= FIRST_PLAYER;
      mv_valid    <= 1'b0;
      mv_player   <= 1'b0;
      mv_row      <= '0;
      mv_col      <= '0;
      ack1        <= 1'b0;
      ack2        <= 1'b0;
      rej1        <= 1'b0;
      rej2        <= 1'b0;
      timeout_evt <= 1'b0;
      move_count  <= '0;
      game_over   <= 1'b0;
      winner      <= WIN_NONE;
      tmo_q       <= TMO_LOAD;
    end else begin
      ack1        <= 1'b0;
      ack2        <= 1'b0;
      rej1        <= rise1;
      rej2        <= rise2;
      timeout_evt <= 1'b0;
      // Down-counter reloads everywhere except idle WAIT cycles.
      tmo_q       <= TMO_LOAD;
      case (state)
        S_WAIT: begin
          if (new_game) begin
            move_count <= '0;
            turn       <= FIRST_PLAYER;
          end else if (cur_rise) begin
            state     <= S_ISSUE;
            mv_valid  <= 1'b1;
            mv_player <= turn;
            mv_row    <= (turn == P2) ? row2 : row1;
            mv_col    <= (turn == P2) ? col2 : col1;
            if (turn == P2) rej2 <= 1'b0;
            else            rej1 <= 1'b0;
          end else if (tmo_hit) begin
            timeout_evt <= 1'b1;
            turn        <= ~turn;
          end else if (TIMEOUT_CYCLES != 0) begin
            tmo_q <= tmo_q - TW'(1);
          end
        end
        S_ISSUE: begin
          if (mv_ready) begin
            mv_valid <= 1'b0;
            state    <= S_RESULT;
          end
        end
        S_RESULT: begin
          if (res_valid) begin
            state <= S_WAIT;
            if (res_illegal) begin
              if (mv_player == P2) rej2 <= 1'b1;
              else                 rej1 <= 1'b1;
            end else begin
              if (mv_player == P2) ack2 <= 1'b1;
              else                 ack1 <= 1'b1;
              move_count <= count_inc;
              if (res_win) begin
                state     <= S_DONE;
                game_over <= 1'b1;
                winner    <= win_code(mv_player);
              end else if (res_full || count_inc == CELLS) begin
                state     <= S_DONE;
                game_over <= 1'b1;
                winner    <= WIN_DRAW;
              end else begin
                turn <= ~turn;
              end
            end
          end
        end
        S_DONE: begin
          if (new_game) begin
            state      <= S_WAIT;
            move_count <= '0;
            turn       <= FIRST_PLAYER;
            game_over  <= 1'b0;
            winner     <= WIN_NONE;
          end
        end
        default: state <= S_WAIT;
      endcase
    end
  end
endmodule
